burst_dma: RTL and testbench



---
 rtl/dma_pkg.sv | 25 ++
 rtl/dma_buf_addr_gen.sv | 16 +
 rtl/burst_dma.sv | 194 +++++++++++++++++++
 tb/tb_burst_dma.sv | 377 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_pkg.sv
// rtl/dma_pkg.sv - shared types and constants for the burst DMA engine
package dma_pkg;

    localparam int WORD_W = 32;
    // Word index must reach MAX_BURST (256) while counting dropped read words.
    localparam int IDX_W = 9;
    localparam logic [3:0] BE_ALL = 4'hF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQUEST,
        ST_HANDSHAKE,
        ST_SEND,
        ST_RECEIVE,
        ST_END
    } dma_state_t;

    function automatic logic [7:0] clamp_count(input logic [7:0] word_count,
                                               input int unsigned max_burst);
        if (32'(word_count) >= max_burst)
            return 8'(max_burst - 1);
        return word_count;
    endfunction

endpackage

// File: rtl/dma_buf_addr_gen.sv
// rtl/dma_buf_addr_gen.sv - buffer word address from burst start, index and accept
module dma_buf_addr_gen
    import dma_pkg::*;
#(
    parameter int BUF_AW = 9
) (
    input  logic [BUF_AW-1:0] start,
    input  logic [IDX_W-1:0]  index,
    input  logic              accept,
    output logic [BUF_AW-1:0] address
);

    // Adding accept looks one word ahead so the RAM read latency is hidden.
    assign address = start + BUF_AW'(index) + BUF_AW'(accept);

endmodule

// File: rtl/burst_dma.sv
// rtl/burst_dma.sv - bus-master burst DMA between local buffer RAM and system bus
module burst_dma
    import dma_pkg::*;
#(
    parameter int BUF_AW    = 9,
    parameter int MAX_BURST = 16
) (
    input  logic              clock,
    input  logic              reset,

    input  logic              cmd_write,
    input  logic              cmd_read,
    input  logic [31:0]       cmd_bus_address,
    input  logic [3:0]        cmd_byte_enable,
    input  logic [BUF_AW-1:0] cmd_buf_start,
    input  logic [7:0]        cmd_word_count,
    output logic              cmd_ready,
    output logic              cmd_done,
    output logic              cmd_error,

    output logic [BUF_AW-1:0] buffer_address,
    output logic [31:0]       buffer_data_in,
    output logic              buffer_write_enable,
    input  logic [31:0]       buffer_data_out,

    input  logic [31:0]       address_dataIN,
    input  logic              end_transactionIN,
    input  logic              data_validIN,
    input  logic              busyIN,
    input  logic              errorIN,

    output logic [31:0]       address_dataOUT,
    output logic [3:0]        byte_enableOUT,
    output logic [7:0]        burst_sizeOUT,
    output logic              read_n_writeOUT,
    output logic              begin_transactionOUT,
    output logic              end_transactionOUT,
    output logic              data_validOUT,
    output logic              busyOUT,

    output logic              request,
    input  logic              granted
);

    dma_state_t        state;
    logic [WORD_W-1:0] addr_q;
    logic [3:0]        be_q;
    logic [BUF_AW-1:0] start_q;
    logic [7:0]        count_q;
    logic              is_read_q;
    logic [IDX_W-1:0]  index_q;

    logic              accept;
    logic              last_word;
    logic              in_range;
    logic [BUF_AW-1:0] gen_address;

    assign accept    = (state == ST_SEND) && !busyIN;
    assign last_word = (index_q == IDX_W'(count_q));
    assign in_range  = (index_q <= IDX_W'(count_q));

    dma_buf_addr_gen #(
        .BUF_AW (BUF_AW)
    ) u_addr_gen (
        .start   (start_q),
        .index   (index_q),
        .accept  (accept),
        .address (gen_address)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            addr_q    <= '0;
            be_q      <= '0;
            start_q   <= '0;
            count_q   <= '0;
            is_read_q <= 1'b0;
            index_q   <= '0;
            cmd_done  <= 1'b0;
            cmd_error <= 1'b0;
        end else begin
            cmd_done  <= 1'b0;
            cmd_error <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cmd_write || cmd_read) begin
                        addr_q    <= cmd_bus_address;
                        be_q      <= cmd_byte_enable;
                        start_q   <= cmd_buf_start;
                        count_q   <= clamp_count(cmd_word_count, MAX_BURST);
                        is_read_q <= !cmd_write;
                        index_q   <= '0;
                        state     <= ST_REQUEST;
                    end
                end
                ST_REQUEST: begin
                    if (errorIN) begin
                        state     <= ST_IDLE;
                        cmd_done  <= 1'b1;
                        cmd_error <= 1'b1;
                    end else if (granted) begin
                        state <= ST_HANDSHAKE;
                    end
                end
                ST_HANDSHAKE: begin
                    if (errorIN) begin
                        state     <= ST_IDLE;
                        cmd_done  <= 1'b1;
                        cmd_error <= 1'b1;
                    end else begin
                        state <= is_read_q ? ST_RECEIVE : ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (errorIN) begin
                        state     <= ST_IDLE;
                        cmd_done  <= 1'b1;
                        cmd_error <= 1'b1;
                    end else if (!busyIN) begin
                        index_q <= index_q + IDX_W'(1);
                        if (last_word) begin
                            state    <= ST_END;
                            cmd_done <= 1'b1;
                        end
                    end
                end
                ST_RECEIVE: begin
                    if (errorIN) begin
                        state     <= ST_IDLE;
                        cmd_done  <= 1'b1;
                        cmd_error <= 1'b1;
                    end else begin
                        // Surplus words from the slave are dropped and stop advancing the index.
                        if (data_validIN && in_range)
                            index_q <= index_q + IDX_W'(1);
                        if (end_transactionIN) begin
                            state    <= ST_END;
                            cmd_done <= 1'b1;
                        end
                    end
                end
                ST_END: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        cmd_ready            = (state == ST_IDLE);
        request              = (state == ST_REQUEST);
        busyOUT              = 1'b0;
        address_dataOUT      = '0;
        byte_enableOUT       = '0;
        burst_sizeOUT        = '0;
        read_n_writeOUT      = 1'b0;
        begin_transactionOUT = 1'b0;
        end_transactionOUT   = 1'b0;
        data_validOUT        = 1'b0;
        buffer_address       = '0;
        buffer_data_in       = '0;
        buffer_write_enable  = 1'b0;
        case (state)
            ST_HANDSHAKE: begin
                begin_transactionOUT = 1'b1;
                address_dataOUT      = addr_q;
                burst_sizeOUT        = count_q;
                byte_enableOUT       = (count_q == 8'd0) ? be_q : BE_ALL;
                read_n_writeOUT      = is_read_q;
                buffer_address       = gen_address;
            end
            ST_SEND: begin
                data_validOUT   = 1'b1;
                address_dataOUT = buffer_data_out;
                buffer_address  = gen_address;
            end
            ST_RECEIVE: begin
                buffer_address      = gen_address;
                buffer_data_in      = address_dataIN;
                buffer_write_enable = data_validIN && !errorIN && in_range;
            end
            ST_END: begin
                end_transactionOUT = !is_read_q;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_burst_dma.sv
// tb/tb_burst_dma.sv - randomized self-checking bench for burst_dma
module tb_burst_dma;

    localparam int BUF_AW = 9;
    localparam int MAXB   = 16;

    logic              clock;
    logic              reset;
    logic              cmd_write, cmd_read;
    logic [31:0]       cmd_bus_address;
    logic [3:0]        cmd_byte_enable;
    logic [BUF_AW-1:0] cmd_buf_start;
    logic [7:0]        cmd_word_count;
    logic              cmd_ready, cmd_done, cmd_error;
    logic [BUF_AW-1:0] buffer_address;
    logic [31:0]       buffer_data_in;
    logic              buffer_write_enable;
    logic [31:0]       buffer_data_out;
    logic [31:0]       address_dataIN;
    logic              end_transactionIN, data_validIN, busyIN, errorIN;
    logic [31:0]       address_dataOUT;
    logic [3:0]        byte_enableOUT;
    logic [7:0]        burst_sizeOUT;
    logic              read_n_writeOUT, begin_transactionOUT, end_transactionOUT;
    logic              data_validOUT, busyOUT;
    logic              request, granted;

    burst_dma #(.BUF_AW(BUF_AW), .MAX_BURST(MAXB)) dut (
        .clock(clock), .reset(reset),
        .cmd_write(cmd_write), .cmd_read(cmd_read),
        .cmd_bus_address(cmd_bus_address), .cmd_byte_enable(cmd_byte_enable),
        .cmd_buf_start(cmd_buf_start), .cmd_word_count(cmd_word_count),
        .cmd_ready(cmd_ready), .cmd_done(cmd_done), .cmd_error(cmd_error),
        .buffer_address(buffer_address), .buffer_data_in(buffer_data_in),
        .buffer_write_enable(buffer_write_enable), .buffer_data_out(buffer_data_out),
        .address_dataIN(address_dataIN), .end_transactionIN(end_transactionIN),
        .data_validIN(data_validIN), .busyIN(busyIN), .errorIN(errorIN),
        .address_dataOUT(address_dataOUT), .byte_enableOUT(byte_enableOUT),
        .burst_sizeOUT(burst_sizeOUT), .read_n_writeOUT(read_n_writeOUT),
        .begin_transactionOUT(begin_transactionOUT), .end_transactionOUT(end_transactionOUT),
        .data_validOUT(data_validOUT), .busyOUT(busyOUT),
        .request(request), .granted(granted)
    );

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  bs;
        logic [3:0]  be;
        logic        rnw;
    } hdr_t;

    typedef struct {
        logic [8:0]  a;
        logic [31:0] d;
    } wr_t;

    int          n_checks = 0;
    int          n_err    = 0;
    logic [31:0] mem [0:511];
    hdr_t        exp_hdr_q[$];
    logic [31:0] exp_words[$];
    wr_t         exp_wr[$];
    logic [31:0] seen_words[$];
    logic [31:0] acc_words[$];
    hdr_t        last_hdr;
    bit          chk_en = 1'b0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Buffer RAM with one-cycle read latency.
    always @(posedge clock) begin
        if (buffer_write_enable)
            mem[buffer_address] <= buffer_data_in;
        buffer_data_out <= mem[buffer_address];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        #2;
        chk("busyOUT_zero", 32'(busyOUT), 32'd0);
        if (chk_en && reset) begin
            if (begin_transactionOUT) begin
                if (exp_hdr_q.size() == 0) begin
                    chk("hdr_unexpected", 32'd1, 32'd0);
                end else begin
                    hdr_t h;
                    h = exp_hdr_q.pop_front();
                    chk("hdr_addr", address_dataOUT, h.addr);
                    chk("hdr_burst", 32'(burst_sizeOUT), 32'(h.bs));
                    chk("hdr_be", 32'(byte_enableOUT), 32'(h.be));
                    chk("hdr_rnw", 32'(read_n_writeOUT), 32'(h.rnw));
                    last_hdr.addr = address_dataOUT;
                    last_hdr.bs   = burst_sizeOUT;
                    last_hdr.be   = byte_enableOUT;
                    last_hdr.rnw  = read_n_writeOUT;
                end
            end
            if (data_validOUT) begin
                seen_words.push_back(address_dataOUT);
                if (!busyIN) begin
                    acc_words.push_back(address_dataOUT);
                    if (exp_words.size() == 0)
                        chk("word_unexpected", 32'd1, 32'd0);
                    else
                        chk("send_word", address_dataOUT, exp_words.pop_front());
                end
            end
            if (buffer_write_enable) begin
                if (exp_wr.size() == 0) begin
                    chk("write_unexpected", 32'(buffer_address), 32'hFFFF_FFFF);
                end else begin
                    wr_t w;
                    w = exp_wr.pop_front();
                    chk("write_addr", 32'(buffer_address), 32'(w.a));
                    chk("write_data", buffer_data_in, w.d);
                end
            end
        end
    end

    function automatic int clampc(input int wc);
        return (wc >= MAXB) ? MAXB - 1 : wc;
    endfunction

    task automatic push_hdr(input logic [31:0] addr, input int c, input logic [3:0] be, input logic rnw);
        hdr_t h;
        h.addr = addr;
        h.bs   = 8'(c);
        h.be   = (c == 0) ? be : 4'hF;
        h.rnw  = rnw;
        exp_hdr_q.push_back(h);
    endtask

    task automatic issue(input logic wr, input logic [8:0] start, input logic [31:0] addr,
                         input logic [3:0] be, input logic [7:0] wc, input int gdly, inout int cyc);
        @(negedge clock);
        cmd_write = wr;
        cmd_read = !wr;
        cmd_buf_start = start;
        cmd_bus_address = addr;
        cmd_byte_enable = be;
        cmd_word_count = wc;
        cyc = 1;
        @(negedge clock);
        cyc++;
        cmd_write = 1'b0;
        cmd_read = 1'b0;
        for (int g = 0; g < gdly; g++) begin
            @(negedge clock);
            cyc++;
        end
        chk("request_high", 32'(request), 32'd1);
        granted = 1'b1;
        @(negedge clock);
        cyc++;
        granted = 1'b0;
    endtask

    task automatic do_write(input logic [8:0] start, input logic [31:0] addr, input logic [3:0] be,
                            input logic [7:0] wc, input int busy_word, input int busy_len,
                            input int gdly, output int lat);
        int c, acc, bcnt, cyc, extra;
        bit done;
        c = clampc(int'(wc));
        for (int k = 0; k <= c; k++)
            exp_words.push_back(mem[9'(int'(start) + k)]);
        push_hdr(addr, c, be, 1'b0);
        issue(1'b1, start, addr, be, wc, gdly, cyc);
        acc = 0;
        bcnt = 0;
        done = 1'b0;
        while (!done && cyc < 400) begin
            if (cmd_done) begin
                done = 1'b1;
            end else begin
                busyIN = 1'b0;
                if (data_validOUT) begin
                    if (acc == busy_word && bcnt < busy_len) begin
                        busyIN = 1'b1;
                        bcnt++;
                    end else begin
                        acc++;
                    end
                end
                @(negedge clock);
                cyc++;
            end
        end
        busyIN = 1'b0;
        lat = cyc;
        extra = (busy_word <= c) ? busy_len : 0;
        chk("write_done_seen", 32'(done), 32'd1);
        chk("write_latency", 32'(lat), 32'(c + 1 + 4 + extra + gdly));
        chk("write_end_txn", 32'(end_transactionOUT), 32'd1);
        chk("write_no_error", 32'(cmd_error), 32'd0);
        chk("write_words_left", 32'(exp_words.size()), 32'd0);
        exp_words.delete();
    endtask

    task automatic do_read(input logic [8:0] start, input logic [31:0] addr, input logic [3:0] be,
                           input logic [7:0] wc, input int extra, input int err_at,
                           input int gdly, input logic [31:0] data_base);
        int c, cyc, k, nsend, guard;
        bit aborted;
        logic [31:0] d;
        c = clampc(int'(wc));
        push_hdr(addr, c, be, 1'b1);
        issue(1'b0, start, addr, be, wc, gdly, cyc);
        @(negedge clock);
        nsend = c + 1 + extra;
        k = 0;
        guard = 0;
        aborted = 1'b0;
        while (k < nsend && !aborted && guard < 200) begin
            guard++;
            if (data_base == 0 && $urandom_range(0, 3) == 0) begin
                data_validIN = 1'b0;
                end_transactionIN = 1'b0;
            end else begin
                d = (data_base != 0) ? data_base + 32'(k) : $urandom;
                data_validIN = 1'b1;
                address_dataIN = d;
                if (k == err_at) begin
                    errorIN = 1'b1;
                    end_transactionIN = 1'b0;
                    aborted = 1'b1;
                end else begin
                    if (k <= c) begin
                        wr_t w;
                        w.a = 9'(int'(start) + k);
                        w.d = d;
                        exp_wr.push_back(w);
                    end
                    end_transactionIN = (k == nsend - 1);
                end
                k++;
            end
            @(negedge clock);
        end
        data_validIN = 1'b0;
        end_transactionIN = 1'b0;
        errorIN = 1'b0;
        chk("read_done", 32'(cmd_done), 32'd1);
        chk("read_error_flag", 32'(cmd_error), 32'(aborted));
        chk("read_ready", 32'(cmd_ready), 32'(aborted));
        chk("read_no_end_txn", 32'(end_transactionOUT), 32'd0);
        chk("read_writes_left", 32'(exp_wr.size()), 32'd0);
        exp_wr.delete();
    endtask

    initial begin
        int lat, c, bw;
        logic [31:0] keep1, keep42;
        reset = 1'b0;
        cmd_write = 1'b0; cmd_read = 1'b0; cmd_bus_address = '0; cmd_byte_enable = '0;
        cmd_buf_start = '0; cmd_word_count = '0; address_dataIN = '0;
        end_transactionIN = 1'b0; data_validIN = 1'b0; busyIN = 1'b0; errorIN = 1'b0;
        granted = 1'b0;
        for (int i = 0; i < 512; i++) mem[i] = $urandom;
        for (int i = 0; i < 4; i++) mem[16 + i] = 32'hC0DE_0010 + 32'(i);
        repeat (3) @(negedge clock);
        chk("rst_ready", 32'(cmd_ready), 32'd1);
        chk("rst_request", 32'(request), 32'd0);
        chk("rst_done", 32'(cmd_done), 32'd0);
        chk("rst_addr_out", address_dataOUT, 32'd0);
        chk("rst_buf_addr", 32'(buffer_address), 32'd0);
        reset = 1'b1;
        chk_en = 1'b1;

        // Four-word write with immediate grant.
        acc_words.delete();
        do_write(9'h010, 32'h4000_0100, 4'hF, 8'd3, 99, 0, 0, lat);
        chk("lit_latency8", 32'(lat), 32'd8);
        chk("lit_nwords", 32'(acc_words.size()), 32'd4);
        chk("lit_word0", acc_words[0], 32'hC0DE_0010);
        chk("lit_word3", acc_words[3], 32'hC0DE_0013);
        chk("lit_hdr_addr", last_hdr.addr, 32'h4000_0100);

        // Busy held for two cycles on word 1.
        @(negedge clock);
        seen_words.delete();
        do_write(9'h010, 32'h4000_0100, 4'hF, 8'd3, 1, 2, 0, lat);
        bw = 0;
        foreach (seen_words[i]) if (seen_words[i] == 32'hC0DE_0011) bw++;
        chk("lit_word1_held", 32'(bw), 32'd3);
        chk("lit_seen_total", 32'(seen_words.size()), 32'd6);

        // Read wrapping the buffer address, plus one surplus word.
        keep1 = mem[1];
        do_read(9'h1FF, 32'h8000_0000, 4'hF, 8'd1, 1, -1, 0, 32'h5EAD_0000);
        chk("lit_wrap_1ff", mem[511], 32'h5EAD_0000);
        chk("lit_wrap_000", mem[0], 32'h5EAD_0001);
        chk("lit_drop_001", mem[1], keep1);
        chk("lit_read_bs", 32'(last_hdr.bs), 32'd1);
        chk("lit_read_rnw", 32'(last_hdr.rnw), 32'd1);

        // Byte enables and count clamp.
        do_write(9'h020, 32'h1000_0000, 4'b0011, 8'd0, 99, 0, 1, lat);
        chk("lit_be_single", 32'(last_hdr.be), 32'h3);
        do_write(9'h020, 32'h1000_0000, 4'b0011, 8'd5, 99, 0, 0, lat);
        chk("lit_be_multi", 32'(last_hdr.be), 32'hF);
        do_write(9'h030, 32'h1000_0040, 4'hF, 8'd200, 99, 0, 0, lat);
        chk("lit_clamp", 32'(last_hdr.bs), 32'd15);

        // Error during word 2 of a read.
        keep42 = mem[9'h042];
        do_read(9'h040, 32'h2000_0000, 4'hF, 8'd5, 0, 2, 0, 32'hE000_0000);
        chk("lit_err_w1", mem[9'h041], 32'hE000_0001);
        chk("lit_err_w2_kept", mem[9'h042], keep42);

        // Randomized mix.
        for (int it = 0; it < 40; it++) begin
            logic [8:0] st;
            logic [7:0] wcr;
            st = 9'($urandom_range(0, 511));
            wcr = 8'($urandom_range(0, 20));
            c = clampc(int'(wcr));
            if ($urandom_range(0, 1) == 0)
                do_write(st, $urandom, 4'($urandom), wcr, $urandom_range(0, c),
                         $urandom_range(0, 3), $urandom_range(0, 3), lat);
            else
                do_read(st, $urandom, 4'($urandom), wcr, $urandom_range(0, 2),
                        ($urandom_range(0, 5) == 0) ? $urandom_range(0, c) : -1,
                        $urandom_range(0, 3), 32'd0);
        end

        // Reset asserted in the middle of a write burst.
        begin
            int cyc, g;
            push_hdr(32'h7000_0000, 7, 4'hF, 1'b0);
            for (int k = 0; k <= 7; k++) exp_words.push_back(mem[9'(16'h100 + k)]);
            issue(1'b1, 9'h100, 32'h7000_0000, 4'hF, 8'd7, 0, cyc);
            g = 0;
            while (!data_validOUT && g < 20) begin
                @(negedge clock);
                g++;
            end
            chk("rst_reached_send", 32'(data_validOUT), 32'd1);
            @(negedge clock);
            chk_en = 1'b0;
            reset = 1'b0;
            #1;
            chk("arst_ready", 32'(cmd_ready), 32'd1);
            chk("arst_valid", 32'(data_validOUT), 32'd0);
            chk("arst_data", address_dataOUT, 32'd0);
            chk("arst_buf_addr", 32'(buffer_address), 32'd0);
            chk("arst_done", 32'(cmd_done), 32'd0);
            exp_words.delete();
            @(negedge clock);
            reset = 1'b1;
            for (int i = 0; i < 4; i++) begin
                @(negedge clock);
                chk("post_rst_no_done", 32'(cmd_done), 32'd0);
                chk("post_rst_ready", 32'(cmd_ready), 32'd1);
            end
        end

        chk("hdr_left", 32'(exp_hdr_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
